serial_rx: RTL and testbench

Serial receiver for the lab serial link: the receive end of the transmit path, sharing its `CLKS_PER_BIT` bit-period convention. It recovers 8N1 frames (idle-high line, one start bit, 8 data bits LSB first, one stop bit) from an asynchronous serial input. It delivers each byte with a one-cycle valid pulse, or a one-cycle framing-error pulse. It sits between the board RX pin and the byte-consuming logic, clocked by the system clock `i_Clock`.

---
 rtl/serial_rx.sv | 142 ++++++++++++++
 tb/tb_serial_rx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_rx.sv
// serial_rx: 8N1 asynchronous serial receiver.
// The line passes through a two-flop synchronizer. A mid-bit sampling FSM then
// recovers each byte and emits either a one-cycle valid pulse or a one-cycle
// framing-error pulse.
module serial_rx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       reset,
  input  logic       i_Clock,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Frame_Err,
  output logic       o_Rx_Busy
);

  // Last cycle of a full bit period, and the offset from the start-bit edge
  // to the start-bit centre.
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF = 16'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  logic       r_Rx_Sync_p0;
  logic       r_Rx_Sync_p1;
  logic       w_Rx;

  state_t     r_State;
  logic [15:0] r_Cnt;
  logic [2:0] r_Idx;
  logic [7:0] r_Sh;
  logic       r_DV;
  logic       r_Err;
  logic [7:0] r_Byte;
  logic       r_Busy;

  // Two-flop synchronizer; both flops reset to the idle-high line level.
  always_ff @(posedge i_Clock or posedge reset) begin
    if (reset) begin
      r_Rx_Sync_p0 <= 1'b1;
      r_Rx_Sync_p1 <= 1'b1;
    end else begin
      r_Rx_Sync_p0 <= i_Rx_Serial;
      r_Rx_Sync_p1 <= r_Rx_Sync_p0;
    end
  end

  assign w_Rx = r_Rx_Sync_p1;

  // Frame FSM. The pulse outputs default low each cycle, so any pulse lasts one cycle.
  always_ff @(posedge i_Clock or posedge reset) begin
    if (reset) begin
      r_State <= IDLE;
      r_Cnt   <= 16'd0;
      r_Idx   <= 3'd0;
      r_Sh    <= 8'h00;
      r_DV    <= 1'b0;
      r_Err   <= 1'b0;
      r_Byte  <= 8'h00;
      r_Busy  <= 1'b0;
    end else begin
      r_DV  <= 1'b0;
      r_Err <= 1'b0;
      case (r_State)
        IDLE: begin
          if (!w_Rx) begin
            r_State <= START;
            r_Cnt   <= 16'd0;
            r_Busy  <= 1'b1;
          end
        end
        START: begin
          if (r_Cnt == HALF) begin
            if (!w_Rx) begin
              r_State <= DATA;
              r_Cnt   <= 16'd0;
              r_Idx   <= 3'd0;
            end else begin
              // The line is high at mid-start, so this was a glitch and is dropped silently.
              r_State <= IDLE;
              r_Busy  <= 1'b0;
            end
          end else begin
            r_Cnt <= r_Cnt + 16'd1;
          end
        end
        DATA: begin
          if (r_Cnt == LAST) begin
            r_Sh[r_Idx] <= w_Rx;
            r_Cnt       <= 16'd0;
            if (r_Idx == 3'd7) begin
              r_State <= STOP;
            end else begin
              r_Idx <= r_Idx + 3'd1;
            end
          end else begin
            r_Cnt <= r_Cnt + 16'd1;
          end
        end
        STOP: begin
          if (r_Cnt == LAST) begin
            if (w_Rx) begin
              // Return to IDLE at mid-stop-bit, so a back-to-back start bit is caught.
              r_Byte  <= r_Sh;
              r_DV    <= 1'b1;
              r_State <= IDLE;
              r_Busy  <= 1'b0;
            end else begin
              r_Err   <= 1'b1;
              r_State <= WAIT_IDLE;
            end
          end else begin
            r_Cnt <= r_Cnt + 16'd1;
          end
        end
        WAIT_IDLE: begin
          // While a break holds the line low, the FSM waits here, so no new frames start.
          if (w_Rx) begin
            r_State <= IDLE;
            r_Busy  <= 1'b0;
          end
        end
        default: begin
          r_State <= IDLE;
          r_Busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_Rx_DV        = r_DV;
  assign o_Rx_Frame_Err = r_Err;
  assign o_Rx_Byte      = r_Byte;
  assign o_Rx_Busy      = r_Busy;

endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: scoreboard bench for serial_rx.
// Four receivers run with different bit periods. The stimulus pushes the
// expected pulse, byte and cycle for each frame; a negedge monitor pops and
// compares whenever a receiver pulses.
`timescale 1ns/1ps
module tb_serial_rx;

  localparam int NCH = 4;
  localparam int CPB [NCH] = '{4, 2, 5, 16};

  typedef struct {
    int         ch;
    logic       err;
    logic [7:0] b;
    int         cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             line [NCH];
  logic [NCH-1:0]   dv;
  logic [NCH-1:0]   ferr;
  logic [NCH-1:0]   busy;
  logic [7:0]       rbyte [NCH];

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q [$];
  exp_t mon_e;
  logic [7:0] last_good [NCH];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NCH; g++) begin : g_dut
    serial_rx #(.CLKS_PER_BIT(CPB[g])) dut (
      .reset          (reset),
      .i_Clock        (clk),
      .i_Rx_Serial    (line[g]),
      .o_Rx_DV        (dv[g]),
      .o_Rx_Byte      (rbyte[g]),
      .o_Rx_Frame_Err (ferr[g]),
      .o_Rx_Busy      (busy[g])
    );
  end

  task automatic chk(input string name, input int ch, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s ch=%0d actual=0x%0h required=0x%0h at cycle %0d", name, ch, act, exp, cyc);
    end
  endtask

  // The line is driven 1 ns after a rising edge. A start bit driven at cycle S
  // is seen by IDLE at edge S+3 (E0). The pulse is visible after edge
  // E0+HALF+1+9*CPB.
  task automatic send(input int ch, input logic [7:0] d, input logic stop,
                      input bit push, input int nbits);
    logic [9:0] bits;
    int         half;
    exp_t       e;
    bits = {stop, d, 1'b0};
    half = (CPB[ch] - 1) / 2;
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk);
      #1;
      line[ch] = bits[i];
      if (i == 0 && push) begin
        e.ch  = ch;
        e.err = ~stop;
        e.b   = stop ? d : last_good[ch];
        e.cyc = cyc + 3 + half + 1 + 9 * CPB[ch];
        exp_q.push_back(e);
        if (stop) last_good[ch] = d;
      end
      repeat (CPB[ch] - 1) @(posedge clk);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Scoreboard monitor: every DV or error pulse must match the head of the queue.
  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (dv[c] && ferr[c]) begin
        checks++;
        failures++;
        $display("FAIL dv_and_err_together ch=%0d actual=both required=exclusive", c);
      end
      if (dv[c] || ferr[c]) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse ch=%0d dv=%0b err=%0b byte=0x%0h cycle=%0d required=none",
                   c, dv[c], ferr[c], rbyte[c], cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("pulse_channel", c, c, mon_e.ch);
          chk("pulse_is_err", c, {31'd0, ferr[c]}, {31'd0, mon_e.err});
          chk("rx_byte", c, {24'd0, rbyte[c]}, {24'd0, mon_e.b});
          chk("pulse_cycle", c, cyc, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    int gs;
    for (int c = 0; c < NCH; c++) begin
      line[c] = 1'b1;
      last_good[c] = 8'h00;
    end

    // Reset state on every channel.
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < NCH; c++) begin
      chk("reset_dv", c, {31'd0, dv[c]}, 0);
      chk("reset_err", c, {31'd0, ferr[c]}, 0);
      chk("reset_busy", c, {31'd0, busy[c]}, 0);
      chk("reset_byte", c, {24'd0, rbyte[c]}, 0);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    idle(5);

    // Single byte 0xA5 at 4 clocks per bit.
    send(0, 8'hA5, 1'b1, 1, 10);
    idle(12);

    // Glitch: one low cycle, then back high.
    @(posedge clk);
    #1 line[0] = 1'b0;
    gs = cyc;
    @(posedge clk);
    #1 line[0] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("glitch_busy_high", 0, {31'd0, busy[0]}, 1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("glitch_busy_cleared_cycle", 0, cyc - gs, 5);
    chk("glitch_busy_low", 0, {31'd0, busy[0]}, 0);
    idle(8);

    // Framing error, then the line is held low as a break.
    send(0, 8'h5A, 1'b0, 1, 10);
    idle(20);
    @(negedge clk);
    chk("break_busy", 0, {31'd0, busy[0]}, 1);
    chk("break_byte_held", 0, {24'd0, rbyte[0]}, 8'hA5);
    @(posedge clk);
    #1 line[0] = 1'b1;
    idle(6);
    @(negedge clk);
    chk("break_exit_busy", 0, {31'd0, busy[0]}, 0);
    send(0, 8'h11, 1'b1, 1, 10);
    idle(12);

    // Back-to-back frames with no idle gap, 40 cycles apart.
    send(0, 8'h00, 1'b1, 1, 10);
    send(0, 8'hFF, 1'b1, 1, 10);
    idle(12);

    // Reset after the third data bit of 0x3C, then a fresh 0x3C.
    send(0, 8'h3C, 1'b1, 0, 4);
    @(posedge clk);
    #1;
    reset = 1'b1;
    line[0] = 1'b1;
    @(negedge clk);
    chk("midreset_dv", 0, {31'd0, dv[0]}, 0);
    chk("midreset_err", 0, {31'd0, ferr[0]}, 0);
    chk("midreset_busy", 0, {31'd0, busy[0]}, 0);
    chk("midreset_byte", 0, {24'd0, rbyte[0]}, 0);
    for (int c = 0; c < NCH; c++) last_good[c] = 8'h00;
    idle(3);
    #1 reset = 1'b0;
    idle(45);
    @(negedge clk);
    chk("post_reset_busy", 0, {31'd0, busy[0]}, 0);
    send(0, 8'h3C, 1'b1, 1, 10);
    idle(12);

    // Sweep of bit periods 2, 5 and 16.
    for (int c = 1; c < NCH; c++) begin
      send(c, 8'hA5, 1'b1, 1, 10);
      idle(2 * CPB[c] + 6);
      send(c, 8'h3C, 1'b1, 1, 10);
      idle(2 * CPB[c] + 6);
    end

    // Bounded drain of outstanding expectations.
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_pulses actual=%0d_outstanding required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
